// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
//
// Contents:
//   stall_t        6-bit stall vector (bit0 pc .. bit5 wb), 1 = Stop
//   Stop/NoStop    per-bit stall encodings
//   StallNone/Id/Ex/Mem  stall patterns in decreasing priority order (Mem > Ex > Id)
//   mc_state_e     multi-cycle sequencer states
//   RstActive      level of the local active-low reset
//   eff_cycles()   fixed-latency count with 0 treated as 1

package pipe_stall_ctrl_pkg;

  typedef logic [5:0] stall_t;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // A stage at Stop holds; the first stage above it at NoStop inserts a bubble.
  localparam stall_t StallNone = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
  localparam stall_t StallId   = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
  localparam stall_t StallEx   = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};
  localparam stall_t StallMem  = {NoStop, Stop,   Stop,   Stop,   Stop,   Stop};

  // Legacy blocks keep their own reset sense; this one is active-low.
  localparam logic RstActive = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIX  = 2'd1,
    S_VAR  = 2'd2
  } mc_state_e;

  // A requested latency of 0 behaves exactly like 1.
  function automatic logic [5:0] eff_cycles(input logic [5:0] n);
    return (n == 6'd0) ? 6'd1 : n;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - request/response bundle between pipeline stages and the stall controller
//
// Signals:
//   stallreq_id/ex/mem  stage stall requests
//   mc_start/mc_var/mc_cycles/mc_done  multi-cycle EX op issue and completion
//   flush_req           exception/eret flush request
//   stall[5:0]          stall vector to pc_reg and the inter-stage registers
//   flush               registered one-cycle flush pulse
//   mc_busy             multi-cycle op in progress
//   mc_timeout          registered one-cycle pulse on variable-latency timeout
// Modports:
//   master  pipeline side (drives requests, receives stall/flush)
//   slave   controller side

interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 6
);

  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             mc_start;
  logic             mc_var;
  logic [CNT_W-1:0] mc_cycles;
  logic             mc_done;
  logic             flush_req;
  logic [5:0]       stall;
  logic             flush;
  logic             mc_busy;
  logic             mc_timeout;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output mc_start, mc_var, mc_cycles, mc_done, flush_req,
    input  stall, flush, mc_busy, mc_timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  mc_start, mc_var, mc_cycles, mc_done, flush_req,
    output stall, flush, mc_busy, mc_timeout
  );

endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer for the 5-stage MIPS32 pipeline
//
// Ports:
//   clk   pipeline clock
//   rst   asynchronous reset, active-low
//   bus   pipe_stall_ctrl_if.slave (stall requests, multi-cycle op control,
//         flush request in; stall vector, flush, mc_busy, mc_timeout out)
// Parameters:
//   CNT_W     width of the fixed-latency counter and of mc_cycles
//   MAX_WAIT  variable-latency wait budget in stall cycles (>= 2)
//   WAIT_W    width of the wait counter (2^WAIT_W > MAX_WAIT)

module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int MAX_WAIT = 64,
  parameter int WAIT_W   = 7
) (
  input  logic                clk,
  input  logic                rst,
  pipe_stall_ctrl_if.slave    bus
);

  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              flush_q, flush_d;
  logic              timeout_q, timeout_d;

  logic [CNT_W-1:0]  n_eff;
  logic              mc_accept;
  logic              mc_hold;
  stall_t            stall_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    flush_d   = 1'b0;
    timeout_d = 1'b0;
    mc_hold   = 1'b0;

    n_eff = (bus.mc_cycles == '0) ? CNT_W'(1) : bus.mc_cycles;

    // A start coincident with a flush is dropped; the flush wins.
    mc_accept = bus.mc_start && (state_q == S_IDLE) && !bus.flush_req;

    unique case (state_q)
      S_IDLE: begin
        if (mc_accept) begin
          if (!bus.mc_var) begin
            // The start cycle is the first stall cycle, so N-1 remain.
            if (n_eff > CNT_W'(1)) begin
              state_d = S_FIX;
              cnt_d   = n_eff - CNT_W'(1);
            end
          end else if (!bus.mc_done) begin
            state_d = S_VAR;
            wcnt_d  = WAIT_W'(1);
          end
        end
      end

      S_FIX: begin
        mc_hold = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_VAR: begin
        // Result valid releases the stall in the same cycle.
        if (bus.mc_done) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else begin
          mc_hold = 1'b1;
          if (wcnt_q == WAIT_W'(MAX_WAIT - 1)) begin
            state_d   = S_IDLE;
            wcnt_d    = '0;
            timeout_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WAIT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        wcnt_d  = '0;
      end
    endcase

    // Flush aborts whatever op is in flight.
    if (bus.flush_req) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      wcnt_d    = '0;
      flush_d   = 1'b1;
      timeout_d = 1'b0;
    end
  end

  always_comb begin
    stall_vec = StallNone;
    if (bus.flush_req) begin
      stall_vec = StallNone;
    end else if (bus.stallreq_mem) begin
      stall_vec = StallMem;
    end else if (bus.stallreq_ex || mc_accept || mc_hold) begin
      stall_vec = StallEx;
    end else if (bus.stallreq_id) begin
      stall_vec = StallId;
    end
  end

  // Stall is forced released for as long as reset is held.
  assign bus.stall      = (rst == RstActive) ? StallNone : stall_vec;
  assign bus.flush      = flush_q;
  assign bus.mc_busy    = (state_q != S_IDLE);
  assign bus.mc_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl against a cycle-count reference model

module tb_pipe_stall_ctrl;

  localparam int CNT_W    = 6;
  localparam int MAX_WAIT = 8;
  localparam int WAIT_W   = 4;

  logic clk;
  logic rst;

  int checks;
  int errors;

  // Reference model: what kind of op is outstanding and how many stall
  // cycles it still owes (fixed) or has already consumed (variable).
  int m_kind;      // 0 none, 1 fixed, 2 variable
  int m_left;      // fixed: stall cycles still owed after the current one
  int m_elapsed;   // variable: stall cycles spent so far, start cycle included
  int m_flush;     // expected registered flush for the current cycle
  int m_to;        // expected registered timeout for the current cycle

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  pipe_stall_ctrl #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind    = 0;
    m_left    = 0;
    m_elapsed = 0;
    m_flush   = 0;
    m_to      = 0;
  endtask

  task automatic drive(input logic sid, input logic sex, input logic smem,
                       input logic start, input logic var_l, input int cyc,
                       input logic done, input logic fl);
    ifc.stallreq_id  = sid;
    ifc.stallreq_ex  = sex;
    ifc.stallreq_mem = smem;
    ifc.mc_start     = start;
    ifc.mc_var       = var_l;
    ifc.mc_cycles    = CNT_W'(cyc);
    ifc.mc_done      = done;
    ifc.flush_req    = fl;
  endtask

  // One pipeline cycle: apply inputs, check outputs, advance the model.
  task automatic cycle(input logic sid, input logic sex, input logic smem,
                       input logic start, input logic var_l, input int cyc,
                       input logic done, input logic fl);
    logic [5:0] exp_stall;
    logic       ex_hold;
    int         n;
    @(negedge clk);
    drive(sid, sex, smem, start, var_l, cyc, done, fl);
    #1;
    if (m_kind == 1)      ex_hold = 1'b1;
    else if (m_kind == 2) ex_hold = !done;
    else                  ex_hold = start;

    if (fl)                  exp_stall = 6'b000000;
    else if (smem)           exp_stall = 6'b011111;
    else if (sex || ex_hold) exp_stall = 6'b001111;
    else if (sid)            exp_stall = 6'b000111;
    else                     exp_stall = 6'b000000;

    check_eq("stall",   32'(ifc.stall),      32'(exp_stall));
    check_eq("mc_busy", 32'(ifc.mc_busy),    32'(m_kind != 0));
    check_eq("flush",   32'(ifc.flush),      32'(m_flush));
    check_eq("timeout", 32'(ifc.mc_timeout), 32'(m_to));

    m_flush = 0;
    m_to    = 0;
    if (fl) begin
      m_kind  = 0;
      m_flush = 1;
    end else if (m_kind == 0) begin
      if (start) begin
        if (!var_l) begin
          n = (cyc == 0) ? 1 : cyc;
          if (n > 1) begin
            m_kind = 1;
            m_left = n - 1;
          end
        end else if (!done) begin
          m_kind    = 2;
          m_elapsed = 1;
        end
      end
    end else if (m_kind == 1) begin
      m_left--;
      if (m_left == 0) m_kind = 0;
    end else begin
      if (done) begin
        m_kind = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == MAX_WAIT) begin
          m_kind = 0;
          m_to   = 1;
        end
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_with_requests_high();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 1, 1, 0, 5, 1, 0);
    #1;
    check_eq("rst_stall",   32'(ifc.stall),      32'(0));
    check_eq("rst_flush",   32'(ifc.flush),      32'(0));
    check_eq("rst_busy",    32'(ifc.mc_busy),    32'(0));
    check_eq("rst_timeout", 32'(ifc.mc_timeout), 32'(0));
    @(negedge clk);
    drive(1, 1, 1, 1, 1, 0, 0, 0);
    #1;
    check_eq("rst_stall_hold", 32'(ifc.stall),   32'(0));
    check_eq("rst_busy_hold",  32'(ifc.mc_busy), 32'(0));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    reset_with_requests_high();
    idle(2);

    // Fixed latency: N=3, then N=0 and N=1 (one stall cycle each).
    cycle(0, 0, 0, 1, 0, 3, 0, 0);
    idle(4);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1, 0, 1, 0, 0);
    idle(2);

    // Variable latency completing on the 6th cycle.
    cycle(0, 0, 0, 1, 1, 0, 0, 0);
    idle(4);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Variable latency start with the result already valid.
    cycle(0, 0, 0, 1, 1, 0, 1, 0);
    idle(1);

    // Variable latency with no completion: timeout.
    cycle(0, 0, 0, 1, 1, 0, 0, 0);
    idle(MAX_WAIT + 3);

    // Priority during a fixed op, counter keeps running under mem stall.
    cycle(0, 0, 0, 1, 0, 5, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    idle(3);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Flush in the 2nd cycle of an N=10 op, then a new op is accepted.
    cycle(0, 0, 0, 1, 0, 10, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 2, 0, 0);
    idle(3);

    // Start coincident with flush, then back-to-back flushes.
    cycle(0, 0, 0, 1, 0, 4, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Async reset in the middle of a variable-latency wait.
    cycle(0, 0, 0, 1, 1, 0, 0, 0);
    idle(2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_stall",   32'(ifc.stall),      32'(0));
    check_eq("async_busy",    32'(ifc.mc_busy),    32'(0));
    check_eq("async_flush",   32'(ifc.flush),      32'(0));
    check_eq("async_timeout", 32'(ifc.mc_timeout), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle(MAX_WAIT + 2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 12)),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage MIPS32 core.
- Collects stall requests from the ID, EX and MEM stages, plus flush requests from the exception logic.
- Drives the shared 6-bit stall vector consumed by pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb); a stage with stall[n]=Stop holds and stall[n+1]=NoStop bubbles.
- Owns the sequencing of multi-cycle EX operations (fixed-latency madd/msub, variable-latency div) so EX does not have to re-assert its request every cycle.

Parameters:
- CNT_W, 6, width of the fixed-latency cycle counter and of the mc_cycles input.
- MAX_WAIT, 64, cycles allowed in variable-latency wait before timeout; must be >= 2.
- WAIT_W, 7, width of the wait-timeout counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- stallreq_id  in  1  load-use hazard from ID, combinational same-cycle.
- stallreq_ex  in  1  generic single-cycle EX stall request.
- stallreq_mem  in  1  data-bus not ready.
- mc_start  in  1  EX issues a multi-cycle op this cycle; honoured only in S_IDLE.
- mc_var  in  1  qualifies mc_start: 1 = variable latency (wait for mc_done), 0 = fixed.
- mc_cycles  in  CNT_W  fixed latency N in cycles; 0 is treated as 1.
- mc_done  in  1  variable-latency unit result valid.
- flush_req  in  1  exception/eret flush.
- stall  out  6  bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb; 1 = Stop.
- flush  out  1  registered one-cycle flush pulse to all stage registers.
- mc_busy  out  1  high while in S_FIX or S_VAR.
- mc_timeout  out  1  registered one-cycle pulse on wait timeout.

Behaviour:
- Reset (rst=0, async): state=S_IDLE, cnt=0, wcnt=0, flush=0, mc_timeout=0.
  - stall is forced to 6'b000000 while rst=0, regardless of other inputs.
- States and transitions:
  - S_IDLE:
    - mc_start & ~mc_var & N>1 → S_FIX with cnt=N-1.
    - mc_start & ~mc_var & N<=1 → stays in S_IDLE.
    - mc_start & mc_var & ~mc_done → S_VAR with wcnt=1.
    - mc_start & mc_var & mc_done → stays in S_IDLE.
  - S_FIX: cnt decrements each cycle; at cnt==1 → S_IDLE.
    - The EX stall therefore covers exactly N cycles, start cycle included.
  - S_VAR:
    - mc_done → S_IDLE; the stall is released in the same cycle mc_done is high.
    - Otherwise wcnt increments; at wcnt==MAX_WAIT-1 → S_IDLE and mc_timeout=1 next cycle.
  - The counters run regardless of stallreq_mem; EX units are independent of downstream stalls.
- Stall vector (combinational from state and requests), priority highest first:
  - flush_req=1 → 000000.
  - stallreq_mem → 011111.
  - stallreq_ex, or the mc_start cycle, or state S_FIX/S_VAR with the release condition not yet met → 001111.
  - stallreq_id → 000111.
  - otherwise → 000000.
- Flush:
  - flush_req in any state → flush=1 on the next clock for exactly one cycle.
  - The same edge forces state=S_IDLE and clears cnt/wcnt, aborting any multi-cycle op.
  - mc_start coincident with flush_req is ignored.
  - Back-to-back flush_req gives flush held high for the matching number of cycles.
- mc_start outside S_IDLE is ignored; EX must not re-issue while mc_busy=1.
- mc_done outside S_VAR is ignored.
- Reset asserted mid-operation aborts immediately (async); no flush or timeout pulse follows deassertion.

Decomposition:
- Shared defines file gains:
  - StallSignal width (5:0), Stop/NoStop.
  - Stall pattern constants: StallNone, StallId, StallEx, StallMem.
  - State encodings: S_IDLE, S_FIX, S_VAR.
  - RstEnable is left untouched for legacy blocks; this block uses a local active-low reset constant.
- A single flat module; no sub-module is needed.

Test Plan:
- Reset check: hold rst=0 with all requests high → stall=000000, flush=0, mc_busy=0; release rst → S_IDLE.
- Fixed latency, N=3: mc_start with mc_cycles=3 → stall=001111 for exactly 3 cycles, mc_busy high for 2 cycles, then 000000. Repeat with mc_cycles=0 and 1 → exactly 1 stall cycle each.
- Variable latency, normal completion: mc_start with mc_var=1, mc_done after 5 cycles → stall=001111 on the start cycle and following cycles, 000000 in the mc_done cycle.
  - With MAX_WAIT=8 and mc_done never asserted → return to S_IDLE after 8 stall cycles, then a single mc_timeout pulse.
- Priority: during S_FIX assert stallreq_mem → 011111 and the counter still expires on time; stallreq_id alone → 000111; stallreq_id with stallreq_ex → 001111.
- Flush mid-operation: flush_req in the 2nd cycle of an N=10 op → stall=000000 that cycle, flush=1 next cycle only, mc_busy=0, and a subsequent mc_start is accepted.
- Async reset mid-S_VAR: drop rst between clock edges → outputs clear immediately, with no mc_timeout or flush afterwards.
